// File: rtl/axi_ethernet_ipic_bridge.sv
// AXI4-Lite slave to IPIC master bridge for the Ethernet register space.
// One held IPIC access per AXI transaction; unanswered accesses are terminated with SLVERR.
module axi_ethernet_ipic_bridge #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
    parameter int unsigned C_TIMEOUT          = 64
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [C_S_AXI_ADDR_WIDTH-1:0] bus2ip_addr,
    output logic [31:0]                   bus2ip_data,
    output logic [3:0]                    bus2ip_be,
    output logic                          bus2ip_cs,
    output logic                          bus2ip_rdce,
    output logic                          bus2ip_wrce,
    input  logic                          ip2bus_rdack,
    input  logic                          ip2bus_wrack,
    input  logic                          ip2bus_error,
    input  logic [31:0]                   ip2bus_data
);

    localparam int unsigned AW   = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned CntW = 10;
    localparam logic [CntW-1:0] TimeoutLast = CntW'(C_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StRdAcc, StRdResp, StWrAcc, StWrResp} state_e;

    state_e          state_q, state_d;
    logic [1:0]      rst_sync_q, rst_sync_d;
    logic            rst_n;
    logic            prio_wr_q, prio_wr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      be_q, be_d;
    logic            cs_q, cs_d;
    logic            rdce_q, rdce_d;
    logic            wrce_q, wrce_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            rvalid_q, rvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            bvalid_q, bvalid_d;
    logic            idle, grant_wr, grant_rd, expired;

    // Reset asserts asynchronously but is released in step with the clock.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end
    assign rst_n = rst_sync_q[1];

    // Round-robin arbitration: the flag only matters when both requests are eligible.
    always_comb begin
        idle     = (state_q == StIdle) && rst_n;
        grant_wr = idle && s_axi_awvalid && s_axi_wvalid && (prio_wr_q || !s_axi_arvalid);
        grant_rd = idle && s_axi_arvalid && !grant_wr;
        expired  = (cnt_q == TimeoutLast);
    end

    always_ff @(posedge s_axi_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    state_d = StWrAcc;
                end else if (grant_rd) begin
                    state_d = StRdAcc;
                end
            end
            StRdAcc:  if (ip2bus_rdack || expired) state_d = StRdResp;
            StRdResp: if (s_axi_rready) state_d = StIdle;
            StWrAcc:  if (ip2bus_wrack || expired) state_d = StWrResp;
            StWrResp: if (s_axi_bready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        s_axi_awready = grant_wr;
        s_axi_wready  = grant_wr;
        s_axi_arready = grant_rd;

        prio_wr_d = prio_wr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        be_d      = be_q;
        cs_d      = cs_q;
        rdce_d    = rdce_q;
        wrce_d    = wrce_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rvalid_d  = rvalid_q;
        bresp_d   = bresp_q;
        bvalid_d  = bvalid_q;

        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    addr_d = s_axi_awaddr;
                    data_d = s_axi_wdata;
                    be_d   = s_axi_wstrb;
                    cs_d   = 1'b1;
                    wrce_d = 1'b1;
                    cnt_d  = '0;
                end else if (grant_rd) begin
                    addr_d = s_axi_araddr;
                    be_d   = 4'hF;
                    cs_d   = 1'b1;
                    rdce_d = 1'b1;
                    cnt_d  = '0;
                end
            end
            StRdAcc: begin
                cnt_d = cnt_q + CntW'(1);
                if (ip2bus_rdack || expired) begin
                    // A matching ack in the expiry cycle still returns a normal response.
                    rdata_d  = ip2bus_rdack ? ip2bus_data : 32'h0;
                    rresp_d  = (!ip2bus_rdack || ip2bus_error) ? 2'b10 : 2'b00;
                    rvalid_d = 1'b1;
                    cs_d     = 1'b0;
                    rdce_d   = 1'b0;
                end
            end
            StRdResp: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    prio_wr_d = !prio_wr_q;
                end
            end
            StWrAcc: begin
                cnt_d = cnt_q + CntW'(1);
                if (ip2bus_wrack || expired) begin
                    bresp_d  = (!ip2bus_wrack || ip2bus_error) ? 2'b10 : 2'b00;
                    bvalid_d = 1'b1;
                    cs_d     = 1'b0;
                    wrce_d   = 1'b0;
                end
            end
            StWrResp: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    prio_wr_d = !prio_wr_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge rst_n) begin
        if (!rst_n) begin
            prio_wr_q <= 1'b1;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            cs_q      <= 1'b0;
            rdce_q    <= 1'b0;
            wrce_q    <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bvalid_q  <= 1'b0;
        end else begin
            prio_wr_q <= prio_wr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            cs_q      <= cs_d;
            rdce_q    <= rdce_d;
            wrce_q    <= wrce_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            bvalid_q  <= bvalid_d;
        end
    end

    assign bus2ip_addr  = addr_q;
    assign bus2ip_data  = data_q;
    assign bus2ip_be    = be_q;
    assign bus2ip_cs    = cs_q;
    assign bus2ip_rdce  = rdce_q;
    assign bus2ip_wrce  = wrce_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_bvalid = bvalid_q;

endmodule

// File: tb/tb_axi_ethernet_ipic_bridge.sv
// Scoreboard bench for axi_ethernet_ipic_bridge: expected IPIC accesses and AXI responses are
// queued at issue time and checked by an independent monitor.
module tb_axi_ethernet_ipic_bridge;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [11:0] awaddr, araddr;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [11:0] b2i_addr;
    logic [31:0] b2i_data;
    logic [3:0]  b2i_be;
    logic        cs, rdce, wrce;
    logic        rdack = 1'b0, wrack = 1'b0, ip_err = 1'b0;
    logic [31:0] ip_data = 32'h0;

    typedef struct {
        logic        is_wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          cs_len;
    } acc_t;

    typedef struct {
        logic        is_wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Responder configuration, set by the stimulus before each request.
    int          ack_at    = 2;
    logic        noack     = 1'b0;
    logic        resp_err  = 1'b0;
    logic [31:0] resp_data = 32'h0;
    logic        stray_rd  = 1'b0, stray_wr = 1'b0, stray_err = 1'b0;

    always #5 clk = ~clk;

    axi_ethernet_ipic_bridge #(
        .C_S_AXI_ADDR_WIDTH(12),
        .C_TIMEOUT         (64)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(aresetn),
        .s_axi_awaddr (awaddr),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .bus2ip_addr  (b2i_addr),
        .bus2ip_data  (b2i_data),
        .bus2ip_be    (b2i_be),
        .bus2ip_cs    (cs),
        .bus2ip_rdce  (rdce),
        .bus2ip_wrce  (wrce),
        .ip2bus_rdack (rdack),
        .ip2bus_wrack (wrack),
        .ip2bus_error (ip_err),
        .ip2bus_data  (ip_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_acc(input logic w, input logic [11:0] a, input logic [31:0] d,
                              input logic [3:0] be, input int len);
        acc_t e;
        e.is_wr = w; e.addr = a; e.data = d; e.be = be; e.cs_len = len;
        acc_q.push_back(e);
    endtask

    task automatic expect_rsp(input logic w, input logic [31:0] d, input logic [1:0] r);
        rsp_t e;
        e.is_wr = w; e.rdata = d; e.resp = r;
        rsp_q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        logic got = 1'b0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (awready && wready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("aw_w_handshake", got, 1);
    endtask

    task automatic axi_read(input logic [11:0] a);
        logic got = 1'b0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (arready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("ar_handshake", got, 1);
    endtask

    task automatic wait_idle();
        logic done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (acc_q.size() == 0 && rsp_q.size() == 0 && !cs && !rvalid && !bvalid) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        chk("drain", done, 1);
    endtask

    // IPIC target model: acks on the ack_at-th cycle of cs, plus injected stray pulses.
    int rcnt = 0;
    always @(negedge clk) begin
        logic hit;
        if (cs) rcnt++;
        else rcnt = 0;
        hit     = cs && (rcnt == ack_at) && !noack;
        rdack   = (hit && rdce) || stray_rd;
        wrack   = (hit && wrce) || stray_wr;
        ip_err  = (hit && resp_err) || stray_err;
        ip_data = resp_data;
    end

    // Monitor: IPIC accesses, AXI responses, stability and exclusivity.
    logic        cs_prev = 1'b0;
    int          cs_len = 0;
    acc_t        cur;
    logic        rv_hold = 1'b0, bv_hold = 1'b0;
    logic [31:0] r_last;
    logic [1:0]  rr_last, br_last;
    always @(negedge clk) begin
        if (cs && !cs_prev) begin
            chk("cs_while_resp", {30'b0, rvalid, bvalid}, 0);
            if (acc_q.size() == 0) begin
                chk("unexpected_access", 1, 0);
                cur.is_wr = wrce; cur.addr = b2i_addr; cur.data = b2i_data;
                cur.be = b2i_be; cur.cs_len = 0;
            end else begin
                cur = acc_q.pop_front();
                chk("acc_ce", {rdce, wrce}, {~cur.is_wr, cur.is_wr});
                if (cur.is_wr) chk("acc_wdata", b2i_data, cur.data);
            end
            cs_len = 1;
        end else if (cs) begin
            cs_len++;
        end
        if (cs) chk("acc_addr_be", {b2i_addr, b2i_be}, {cur.addr, cur.be});
        if (!cs && cs_prev) chk("cs_len", cs_len, cur.cs_len);
        cs_prev = cs;

        if (awvalid || arvalid) begin
            chk("no_accept_busy", (awready | wready | arready) & (cs | rvalid | bvalid), 0);
            chk("aw_w_ready_pair", awready, wready);
        end

        if (rv_hold) chk("r_stable", {rvalid, rdata, rresp}, {1'b1, r_last, rr_last});
        if (bv_hold) chk("b_stable", {bvalid, bresp}, {1'b1, br_last});
        rv_hold = rvalid && !rready; r_last = rdata; rr_last = rresp;
        bv_hold = bvalid && !bready; br_last = bresp;

        if ((rvalid && rready) || (bvalid && bready)) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("rsp_kind", bvalid, e.is_wr);
                if (e.is_wr) begin
                    chk("bresp", bresp, e.resp);
                end else begin
                    chk("rdata", rdata, e.rdata);
                    chk("rresp", rresp, e.resp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        awaddr = 12'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 12'h0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {awready, wready, arready}, 0);
        chk("rst_valid_resp", {bvalid, rvalid, bresp, rresp}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ipic", {cs, rdce, wrce, b2i_be, b2i_addr}, 0);
        chk("rst_ipic_data", b2i_data, 0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        aresetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Read with ack on the 4th cs cycle.
        ack_at = 4; resp_data = 32'hCAFE_0001; resp_err = 1'b0;
        expect_acc(1'b0, 12'h404, 32'h0, 4'hF, 4);
        expect_rsp(1'b0, 32'hCAFE_0001, 2'b00);
        axi_read(12'h404);
        wait_idle();

        // Write with error qualifier on the ack.
        ack_at = 3; resp_err = 1'b1;
        expect_acc(1'b1, 12'h708, 32'h1234_5678, 4'h3, 3);
        expect_rsp(1'b1, 32'h0, 2'b10);
        axi_write(12'h708, 32'h1234_5678, 4'h3);
        wait_idle();
        resp_err = 1'b0;

        // Unmapped read: no ack, terminated after 64 cycles.
        noack = 1'b1; resp_data = 32'hFFFF_FFFF;
        expect_acc(1'b0, 12'h010, 32'h0, 4'hF, 64);
        expect_rsp(1'b0, 32'h0, 2'b10);
        axi_read(12'h010);
        wait_idle();
        noack = 1'b0;

        // Ack in the expiry cycle wins.
        ack_at = 64; resp_data = 32'h5555_AAAA;
        expect_acc(1'b0, 12'h300, 32'h0, 4'hF, 64);
        expect_rsp(1'b0, 32'h5555_AAAA, 2'b00);
        axi_read(12'h300);
        wait_idle();

        // Stalled read response with stray acks and a pending write.
        ack_at = 2; resp_data = 32'h0BAD_F00D; rready = 1'b0;
        expect_acc(1'b0, 12'h404, 32'h0, 4'hF, 2);
        expect_rsp(1'b0, 32'h0BAD_F00D, 2'b00);
        expect_acc(1'b1, 12'h604, 32'hDEAD_BEEF, 4'hF, 2);
        expect_rsp(1'b1, 32'h0, 2'b00);
        axi_read(12'h404);
        begin
            logic got = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (rvalid) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("rvalid_seen", got, 1);
        end
        @(posedge clk); #1;
        fork
            axi_write(12'h604, 32'hDEAD_BEEF, 4'hF);
        join_none
        for (int i = 0; i < 10; i++) begin
            stray_wr = (i == 2); stray_rd = (i == 4); stray_err = (i == 6);
            @(posedge clk); #1;
        end
        stray_wr = 1'b0; stray_rd = 1'b0; stray_err = 1'b0;
        rready = 1'b1;
        wait_idle();

        // Simultaneous requests: six completions so far leave write-first priority.
        ack_at = 2; resp_data = 32'hA5A5_0000;
        expect_acc(1'b1, 12'h700, 32'h1111_1111, 4'hF, 2);
        expect_rsp(1'b1, 32'h0, 2'b00);
        expect_acc(1'b0, 12'h404, 32'h0, 4'hF, 2);
        expect_rsp(1'b0, 32'hA5A5_0000, 2'b00);
        expect_acc(1'b1, 12'h704, 32'h2222_2222, 4'hC, 2);
        expect_rsp(1'b1, 32'h0, 2'b00);
        fork
            axi_read(12'h404);
            begin
                axi_write(12'h700, 32'h1111_1111, 4'hF);
                axi_write(12'h704, 32'h2222_2222, 4'hC);
            end
        join
        wait_idle();

        // Reset in the second access cycle drops the read without a response.
        noack = 1'b1;
        expect_acc(1'b0, 12'h0A0, 32'h0, 4'hF, 2);
        axi_read(12'h0A0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_ctl", {cs, rdce, wrce, rvalid, bvalid, arready, awready, wready}, 0);
        chk("rst_mid_addr_be", {b2i_addr, b2i_be}, 0);
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        noack = 1'b0; ack_at = 3; resp_data = 32'h7766_5544;
        expect_acc(1'b0, 12'h200, 32'h0, 4'hF, 3);
        expect_rsp(1'b0, 32'h7766_5544, 2'b00);
        axi_read(12'h200);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_ethernet_ipic_bridge.md
Name: axi_ethernet_ipic_bridge

Overview:
- AXI4-Lite slave to IPIC master bridge for the Ethernet register space (0x000-0x7FC). Sits directly upstream of the IPIC chip-select/ack multiplexer.
- Converts each AXI read or write into one held IPIC access, waits for the matching ack, and returns the AXI response.
- A bounded timeout terminates accesses to unmapped space (e.g. 0x000-0x1FF, which never acks) with SLVERR.

Parameters:
- C_S_AXI_ADDR_WIDTH, 12, byte address width; fixed at 12 for this core.
- C_TIMEOUT, 64, access cycles without ack before forced termination; legal range 8-1023.

Ports:
- s_axi_aclk  in  1  sole clock
- s_axi_aresetn  in  1  asynchronous, active-low reset
- s_axi_awaddr  in  12  write address
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake
- s_axi_bresp  out  2  OKAY=00, SLVERR=10
- s_axi_bvalid / s_axi_bready  out/in  1  B handshake
- s_axi_araddr  in  12  read address
- s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  OKAY=00, SLVERR=10
- s_axi_rvalid / s_axi_rready  out/in  1  R handshake
- bus2ip_addr  out  12  latched access address
- bus2ip_data  out  32  latched write data
- bus2ip_be  out  4  latched wstrb; 4'hF on reads
- bus2ip_cs  out  1  access in progress
- bus2ip_rdce  out  1  read access in progress
- bus2ip_wrce  out  1  write access in progress
- ip2bus_rdack  in  1  read complete (single-cycle pulse)
- ip2bus_wrack  in  1  write complete (single-cycle pulse)
- ip2bus_error  in  1  error qualifier, valid with ack
- ip2bus_data  in  32  read data, valid with rdack

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; all outputs 0, including ready/valid, resp, rdata, bus2ip_*; priority flag = write-first; timeout counter = 0.
- FSM states: IDLE, RD_ACC, RD_RESP, WR_ACC, WR_RESP.
- IDLE, write eligible = awvalid & wvalid. Both channels are accepted in the same cycle; awready = wready = 1 for exactly that cycle, combinational from state and valids only.
- IDLE, read eligible = arvalid. arready = 1 for that cycle.
- Both eligible: the priority flag decides; the flag toggles after each completed transaction (round-robin). Only one handshake occurs per cycle.
- Partial AW without W (or W without AW) is not accepted; the bridge waits in IDLE.
- Handshake cycle N: latch addr, data and be; enter RD_ACC or WR_ACC. cs and rdce/wrce are registered high from cycle N+1 and held with stable addr, data and be until termination.
- RD_ACC: first cycle with ip2bus_rdack=1 → latch ip2bus_data into rdata; rresp = error ? 10 : 00; go to RD_RESP.
- WR_ACC: first cycle with ip2bus_wrack=1 → bresp = error ? 10 : 00; go to WR_RESP.
- cs/ce deassert on the edge after the ack; rvalid/bvalid assert on that same edge (ack-to-valid latency 1).
- Non-matching ack (wrack in RD_ACC, rdack in WR_ACC) and any ack or error in IDLE/RESP are ignored. error without ack is ignored.
- Timeout: the counter clears on entry to an ACC state and increments each ACC cycle. At count = C_TIMEOUT-1 with no matching ack, the access terminates as above with resp 10; rdata = 0 on reads.
- Ack on the same cycle as timeout expiry: the ack wins (normal response).
- RD_RESP: rvalid held with stable rdata/rresp until rready; the handshake cycle returns to IDLE.
- WR_RESP: bvalid held with stable bresp until bready; the handshake cycle returns to IDLE.
- A new request can be accepted the cycle after a response handshake, not the same cycle.
- bus2ip_addr, data and be hold their last values when idle; only cs/ce indicate validity.
- Reset mid-operation: the transaction is dropped, outputs return to reset values immediately, and no response is issued.
- At most one IPIC access is outstanding at any time.

Test Plan:
- Read 0x404, model acks rdack with data 0xCAFE0001 four cycles after cs rises → single arready pulse; cs/rdce high 4 cycles, addr=0x404, be=F; rvalid next edge, rdata=0xCAFE0001, rresp=00.
- Write 0x708 data 0x12345678 wstrb 0x3, wrack+error on the same cycle → wrce held until ack; bus2ip_data=0x12345678, be=0x3; bresp=10.
- Read 0x010, no ack, C_TIMEOUT=64 → cs high exactly 64 cycles; rvalid with rdata=0, rresp=10.
- arvalid and awvalid+wvalid together, three times in a row → order write, read, write; one access at a time, cs never overlaps.
- rready held low 10 cycles after rvalid; stray wrack and rdack pulses injected → rvalid/rdata stable, no new access starts, stray acks ignored.
- Assert aresetn low during RD_ACC cycle 2, release, then issue read 0x200 → all outputs 0 during reset, no response for the dropped read, the new read completes normally.
